bomb_scheduler: RTL
===================

// Module: bomb_scheduler
// PURPOSE
//  Owns the bomb slot pool for both players: arbitrates placement requests, allocates slots,
//  times fuse and blast per slot and supports chain detonation.
//  Sits between player/keycode logic and the bomb/blast draw + collision logic, all on frame_clk.
//  Slot outputs carry X/Y/size per slot, so draw logic needs no per-bomb state of its own.
// PARAMETERS
//  NUM_SLOTS       4    bomb slots in the pool (2..8)
//  MAX_PER_PLAYER  2    max simultaneously active bombs one player may own
//  FUSE_FRAMES     120  frames from placement to explosion (>=2)
//  BLAST_FRAMES    30   frames a slot stays in blast before freeing (>=1)
//  TILE_SHIFT      5    placement snaps to 2**TILE_SHIFT pixel grid
// PORTS
//  frame_clk      in   1            frame clock; all state updates on rising edge
//  Reset          in   1            synchronous, active-low reset (0 = reset)
//  place_req      in   2            [i]=1: player i requests a bomb (level; rising edge acts)
//  p0X, p0Y       in   10 each      player 0 position, pixels
//  p1X, p1Y       in   10 each      player 1 position, pixels
//  chain_hit      in   NUM_SLOTS    [s]=1: slot s touched by another blast -> detonate early
//  place_ack      out  2            one-frame pulse: request from player i granted
//  slot_active    out  NUM_SLOTS    slot in FUSE or BLAST
//  slot_blast     out  NUM_SLOTS    slot in BLAST
//  slot_owner     out  NUM_SLOTS    owning player of slot s
//  explode_pulse  out  NUM_SLOTS    one-frame pulse on FUSE->BLAST
//  bombX, bombY   out  NUM_SLOTS*10 flattened, slot s at [10*s +: 10]; snapped position
//  bombS          out  NUM_SLOTS*10 flattened draw size per slot
// BEHAVIOUR
//  Reset (Reset==0 at edge): all slots IDLE, timers 0, bombX=700, bombY=500 (offscreen),
//   bombS=0, all pulses/flags/owners 0, RR pointer -> player 0, req history regs = 2'b11
//   (a key held through reset release does not place).
//  Request edge: req_edge[i] = place_req[i] & ~prev[i]; prev <= place_req every frame.
//  Eligibility of player i: a slot is IDLE (sampled pre-edge), owned count < MAX_PER_PLAYER,
//   and no active slot already holds the snapped tile (x>>TILE_SHIFT, y>>TILE_SHIFT equal).
//  Arbitration: at most one grant per frame. One eligible edge -> grant it. Both eligible ->
//   grant RR pointer player, pointer flips to other. Losing/ineligible edges are dropped, not queued.
//  Grant: lowest-index IDLE slot -> FUSE, timer=FUSE_FRAMES-1, owner=i,
//   bombX/Y = {pos[9:TILE_SHIFT], TILE_SHIFT'b0}; place_ack[i]=1 for that one frame (latency 1 edge).
//  FUSE: timer-- each frame; bombS alternates 4,6,4,... starting 4 on the grant frame.
//   timer==0 or chain_hit[s] -> BLAST, timer=BLAST_FRAMES-1, explode_pulse[s]=1 one frame, bombS=16.
//  BLAST: timer--; at timer==0 -> IDLE, bombX/Y back to 700/500, bombS=0. chain_hit ignored.
//  IDLE: chain_hit ignored; slot frees on BLAST->IDLE edge and is grantable only from next frame.
//  Simultaneous: chain_hit and timer==0 same frame -> single explode_pulse. Grant and another
//   slot exploding same frame are independent. Two slots may explode in one frame.
//  Owner counts derived combinationally from slot_active & slot_owner; never stored separately.
//  Timer width = $clog2(max(FUSE_FRAMES,BLAST_FRAMES)); no wrap possible (reload before 0-1).
// STRUCTURE
//  Package bomb_pkg: slot_state_t enum {IDLE,FUSE,BLAST}, OFFSCREEN_X=700, OFFSCREEN_Y=500,
//   BOMB_S_SMALL=4, BOMB_S_BIG=6, BLAST_S=16.
//  Sub-module bomb_slot (one instance per slot): state/timer FSM, position regs, bombS,
//   explode_pulse; inputs grant, owner, snapped X/Y, chain_hit.
//  bomb_scheduler top: edge detect, eligibility, RR arbiter, lowest-free-slot priority encoder.
// TESTING
//  1 P0 edge at (100,70), all idle -> frame+1: place_ack=01, slot0 FUSE, bombX=96, bombY=64, bombS=4.
//  2 Hold slot0 -> explode_pulse[0] exactly 120 frames after grant; IDLE 30 frames later, X/Y=700/500.
//  3 P0 and P1 edges same frame, different tiles -> P0 granted; repeat -> P1 granted (RR).
//  4 P0 places 2 bombs, 3rd edge on new tile -> no ack; P1 edge on P0's occupied tile -> no ack.
//  5 chain_hit[1] at fuse frame 10 -> explode_pulse[1] next edge; chain_hit during BLAST no effect.
//  6 Reset low mid-FUSE with place_req held -> all outputs reset values; release -> no placement.

Source files
------------

// File: rtl/bomb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_pkg
//  Purpose  : Shared slot states and draw constants for the bomb scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package bomb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

    localparam logic [9:0] OFFSCREEN_X  = 10'd700;
    localparam logic [9:0] OFFSCREEN_Y  = 10'd500;
    localparam logic [9:0] BOMB_S_SMALL = 10'd4;
    localparam logic [9:0] BOMB_S_BIG   = 10'd6;
    localparam logic [9:0] BLAST_S      = 10'd16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bomb_slot.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_slot
//  Purpose  : One bomb slot: fuse/blast timer FSM, snapped position and size.
//  Revision : 1.0  initial release
// ============================================================================
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_grant,
    input  logic       i_owner,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_chain,
    output logic       o_active,
    output logic       o_blast,
    output logic       o_owner,
    output logic       o_explode,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic [9:0] o_s
);

    localparam int TW = $clog2(max_int(FUSE_FRAMES, BLAST_FRAMES));
    localparam logic [TW-1:0] C_FUSE_LOAD  = TW'(FUSE_FRAMES - 1);
    localparam logic [TW-1:0] C_BLAST_LOAD = TW'(BLAST_FRAMES - 1);

    slot_state_t   r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic [9:0]    r_x, r_y, r_s, w_x_nxt, w_y_nxt, w_s_nxt;
    logic          r_owner, w_owner_nxt;
    logic          r_explode, w_explode_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_timer   <= '0;
            r_x       <= OFFSCREEN_X;
            r_y       <= OFFSCREEN_Y;
            r_s       <= '0;
            r_owner   <= 1'b0;
            r_explode <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_s       <= w_s_nxt;
            r_owner   <= w_owner_nxt;
            r_explode <= w_explode_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer;
        w_x_nxt       = r_x;
        w_y_nxt       = r_y;
        w_s_nxt       = r_s;
        w_owner_nxt   = r_owner;
        w_explode_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_grant) begin
                    w_state_nxt = FUSE;
                    w_timer_nxt = C_FUSE_LOAD;
                    w_owner_nxt = i_owner;
                    w_x_nxt     = i_x;
                    w_y_nxt     = i_y;
                    w_s_nxt     = BOMB_S_SMALL;
                end
            end
            FUSE: begin
                // A chain hit on the natural-expiry frame still yields a single pulse.
                if (r_timer == '0 || i_chain) begin
                    w_state_nxt   = BLAST;
                    w_timer_nxt   = C_BLAST_LOAD;
                    w_explode_nxt = 1'b1;
                    w_s_nxt       = BLAST_S;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                    w_s_nxt     = (r_s == BOMB_S_SMALL) ? BOMB_S_BIG : BOMB_S_SMALL;
                end
            end
            BLAST: begin
                if (r_timer == '0) begin
                    w_state_nxt = IDLE;
                    w_x_nxt     = OFFSCREEN_X;
                    w_y_nxt     = OFFSCREEN_Y;
                    w_s_nxt     = '0;
                    w_owner_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign o_active  = (r_state != IDLE);
    assign o_blast   = (r_state == BLAST);
    assign o_owner   = r_owner;
    assign o_explode = r_explode;
    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_s       = r_s;

endmodule
`default_nettype wire

// File: rtl/bomb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bomb_scheduler
//  Purpose  : Bomb slot pool for two players: request arbitration and slot allocation.
//  Revision : 1.0  initial release
// ============================================================================
module bomb_scheduler
    import bomb_pkg::*;
#(
    parameter int NUM_SLOTS      = 4,
    parameter int MAX_PER_PLAYER = 2,
    parameter int FUSE_FRAMES    = 120,
    parameter int BLAST_FRAMES   = 30,
    parameter int TILE_SHIFT     = 5
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [1:0]              place_req,
    input  logic [9:0]              p0X,
    input  logic [9:0]              p0Y,
    input  logic [9:0]              p1X,
    input  logic [9:0]              p1Y,
    input  logic [NUM_SLOTS-1:0]    chain_hit,
    output logic [1:0]              place_ack,
    output logic [NUM_SLOTS-1:0]    slot_active,
    output logic [NUM_SLOTS-1:0]    slot_blast,
    output logic [NUM_SLOTS-1:0]    slot_owner,
    output logic [NUM_SLOTS-1:0]    explode_pulse,
    output logic [NUM_SLOTS*10-1:0] bombX,
    output logic [NUM_SLOTS*10-1:0] bombY,
    output logic [NUM_SLOTS*10-1:0] bombS
);

    localparam int SW = $clog2(NUM_SLOTS);
    localparam int CW = $clog2(NUM_SLOTS + 1);
    localparam logic [9:0] C_TILE_MASK = ~10'((1 << TILE_SHIFT) - 1);

    logic [1:0]           r_prev;
    logic                 r_rr;
    logic [1:0]           r_ack;

    logic [1:0]           w_edge;
    logic [9:0]           w_snap_x [2];
    logic [9:0]           w_snap_y [2];
    logic [CW-1:0]        w_cnt [2];
    logic [1:0]           w_tile_hit;
    logic [1:0]           w_elig;
    logic                 w_any_idle;
    logic [SW-1:0]        w_free_idx;
    logic                 w_gnt_valid;
    logic                 w_gnt_player;
    logic [9:0]           w_gnt_x, w_gnt_y;
    logic [NUM_SLOTS-1:0] w_slot_grant;

    assign w_edge      = place_req & ~r_prev;
    assign w_snap_x[0] = p0X & C_TILE_MASK;
    assign w_snap_y[0] = p0Y & C_TILE_MASK;
    assign w_snap_x[1] = p1X & C_TILE_MASK;
    assign w_snap_y[1] = p1Y & C_TILE_MASK;

    // Descending scan so the lowest-index idle slot is the one left in w_free_idx.
    always_comb begin
        w_any_idle = 1'b0;
        w_free_idx = '0;
        w_cnt[0]   = '0;
        w_cnt[1]   = '0;
        w_tile_hit = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (!slot_active[s]) begin
                w_any_idle = 1'b1;
                w_free_idx = SW'(s);
            end else begin
                w_cnt[slot_owner[s]] = w_cnt[slot_owner[s]] + CW'(1);
                for (int p = 0; p < 2; p++) begin
                    if (bombX[10*s +: 10] == w_snap_x[p] && bombY[10*s +: 10] == w_snap_y[p])
                        w_tile_hit[p] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_elig = '0;
        for (int p = 0; p < 2; p++) begin
            w_elig[p] = w_edge[p] && w_any_idle && (w_cnt[p] < CW'(MAX_PER_PLAYER))
                        && !w_tile_hit[p];
        end
        w_gnt_valid  = |w_elig;
        w_gnt_player = (w_elig == 2'b11) ? r_rr : w_elig[1];
        w_gnt_x      = w_gnt_player ? w_snap_x[1] : w_snap_x[0];
        w_gnt_y      = w_gnt_player ? w_snap_y[1] : w_snap_y[0];
    end

    // History resets high so a key held through reset release is not an edge.
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_prev <= 2'b11;
            r_rr   <= 1'b0;
            r_ack  <= 2'b00;
        end else begin
            r_prev <= place_req;
            r_ack  <= w_gnt_valid ? (w_gnt_player ? 2'b10 : 2'b01) : 2'b00;
            if (w_elig == 2'b11)
                r_rr <= ~r_rr;
        end
    end

    assign place_ack = r_ack;

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_slot_grant[gi] = w_gnt_valid && (w_free_idx == SW'(gi));

            bomb_slot #(
                .FUSE_FRAMES  (FUSE_FRAMES),
                .BLAST_FRAMES (BLAST_FRAMES)
            ) u_slot (
                .clk       (frame_clk),
                .rst_n     (Reset),
                .i_grant   (w_slot_grant[gi]),
                .i_owner   (w_gnt_player),
                .i_x       (w_gnt_x),
                .i_y       (w_gnt_y),
                .i_chain   (chain_hit[gi]),
                .o_active  (slot_active[gi]),
                .o_blast   (slot_blast[gi]),
                .o_owner   (slot_owner[gi]),
                .o_explode (explode_pulse[gi]),
                .o_x       (bombX[10*gi +: 10]),
                .o_y       (bombY[10*gi +: 10]),
                .o_s       (bombS[10*gi +: 10])
            );
        end
    endgenerate

endmodule
`default_nettype wire
